// File: rtl/cpu_irq_pkg.sv
// -----------------------------------------------------------------------------
// cpu_irq_pkg
// Shared definitions for the CPU interrupt controller: default source count,
// identifier width derived from it, and the controller state encoding.
// -----------------------------------------------------------------------------
package cpu_irq_pkg;

  localparam int NUM_SRC_DEF = 8;
  localparam int ID_W_DEF    = $clog2(NUM_SRC_DEF);

  // IDLE    : no enabled request outstanding
  // REQ     : interrupt raised towards cpu_pc, waiting for a grant
  // SERVICE : one source accepted, waiting for end-of-service acknowledge
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

endpackage : cpu_irq_pkg

// File: rtl/cpu_irq_prio.sv
// -----------------------------------------------------------------------------
// cpu_irq_prio
// Combinational fixed-priority encoder: the lowest set index of req wins.
//
// Ports
//   req   in  NUM_SRC  enabled pending request vector
//   id    out ID_W     index of the winning request (0 when none)
//   valid out 1        at least one request bit is set
// -----------------------------------------------------------------------------
module cpu_irq_prio
  import cpu_irq_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int ID_W    = ID_W_DEF
) (
  input  logic [NUM_SRC-1:0] req,
  output logic [ID_W-1:0]    id,
  output logic               valid
);

  // Scan from the top down so the last hit, i.e. the lowest index, wins.
  always_comb begin
    id    = '0;
    valid = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        id    = ID_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule : cpu_irq_prio

// File: rtl/cpu_irq_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_irq_ctrl
// Edge-triggered, maskable, non-nesting interrupt controller in front of
// cpu_pc. Rising edges on irq_src set pending bits; the lowest-index enabled
// pending source is requested; a grant moves it into service until the CPU
// acknowledges the end of service.
//
// Ports
//   clk             in  1        clock, rising edge
//   reset           in  1        asynchronous reset, active low
//   irq_src         in  NUM_SRC  peripheral interrupt lines (rising edge = request)
//   mask_we         in  1        write mask_wdata into the enable mask
//   mask_wdata      in  NUM_SRC  new enable mask, 1 = enabled
//   interrupt_grant in  1        cpu_pc accepts the current request (1 cycle)
//   irq_ack         in  1        CPU end-of-service pulse (1 cycle)
//   interrupt       out 1        registered request line to cpu_pc
//   irq_id          out ID_W     source being requested or serviced
//   irq_pending     out NUM_SRC  pending-request register
//   irq_mask        out NUM_SRC  enable mask
//   busy            out 1        high while a source is in service
// -----------------------------------------------------------------------------
module cpu_irq_ctrl
  import cpu_irq_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int ID_W    = ID_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic               interrupt_grant,
  input  logic               irq_ack,
  output logic               interrupt,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_SRC-1:0] irq_pending,
  output logic [NUM_SRC-1:0] irq_mask,
  output logic               busy
);

  irq_state_e         state_q, state_d;
  logic               interrupt_q, interrupt_d;
  logic [ID_W-1:0]    irq_id_q, irq_id_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] prev_src_q, prev_src_d;

  logic [NUM_SRC-1:0] src_rise;
  logic [NUM_SRC-1:0] pend_clr;
  logic [NUM_SRC-1:0] req_vec;
  logic [ID_W-1:0]    top_id;
  logic               top_valid;

  // The mask only gates request generation; pending bits collect regardless.
  assign req_vec = pending_q & mask_q;

  cpu_irq_prio #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_prio (
    .req   (req_vec),
    .id    (top_id),
    .valid (top_valid)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    interrupt_d = interrupt_q;
    irq_id_d    = irq_id_q;
    pend_clr    = '0;
    src_rise    = irq_src & ~prev_src_q;

    unique case (state_q)
      IDLE: begin
        if (top_valid) begin
          state_d     = REQ;
          interrupt_d = 1'b1;
          irq_id_d    = top_id;
        end
      end
      REQ: begin
        if (!top_valid) begin
          // Request withdrawn (e.g. masked off): drop the line, keep pending.
          state_d     = IDLE;
          interrupt_d = 1'b0;
        end else if (interrupt_grant) begin
          // cpu_pc accepted the id it was shown, so irq_id_q is held as-is.
          state_d     = SERVICE;
          interrupt_d = 1'b0;
          pend_clr    = NUM_SRC'(1) << irq_id_q;
        end else begin
          irq_id_d = top_id;
        end
      end
      SERVICE: begin
        if (irq_ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        interrupt_d = 1'b0;
      end
    endcase

    // A new edge on the granted source wins over its clear.
    pending_d  = (pending_q & ~pend_clr) | src_rise;
    mask_d     = mask_we ? mask_wdata : mask_q;
    prev_src_d = irq_src;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      interrupt_q <= 1'b0;
      irq_id_q    <= '0;
      pending_q   <= '0;
      mask_q      <= '0;
      prev_src_q  <= '0;
    end else begin
      state_q     <= state_d;
      interrupt_q <= interrupt_d;
      irq_id_q    <= irq_id_d;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      prev_src_q  <= prev_src_d;
    end
  end

  assign interrupt   = interrupt_q;
  assign irq_id      = irq_id_q;
  assign irq_pending = pending_q;
  assign irq_mask    = mask_q;
  assign busy        = (state_q == SERVICE);

endmodule : cpu_irq_ctrl

// File: tb/tb_cpu_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_irq_ctrl
// Self-checking bench for cpu_irq_ctrl: a directed vector table, a reset
// abort sequence, then randomized traffic compared against a behavioural model.
// -----------------------------------------------------------------------------
module tb_cpu_irq_ctrl;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] irq_src;
  logic         mask_we;
  logic [N-1:0] mask_wdata;
  logic         interrupt_grant;
  logic         irq_ack;
  logic         interrupt;
  logic [2:0]   irq_id;
  logic [N-1:0] irq_pending;
  logic [N-1:0] irq_mask;
  logic         busy;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cpu_irq_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .irq_src         (irq_src),
    .mask_we         (mask_we),
    .mask_wdata      (mask_wdata),
    .interrupt_grant (interrupt_grant),
    .irq_ack         (irq_ack),
    .interrupt       (interrupt),
    .irq_id          (irq_id),
    .irq_pending     (irq_pending),
    .irq_mask        (irq_mask),
    .busy            (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: one call per clock edge, using the inputs about to be
  // sampled. phase: 0 = nothing outstanding, 1 = requesting, 2 = in service.
  // ---------------------------------------------------------------------------
  logic [N-1:0] m_pend, m_mask, m_prev;
  logic         m_int;
  int           m_id;
  int           m_phase;

  function automatic int lowest_set(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_mask = '0; m_prev = '0; m_int = 1'b0; m_id = 0; m_phase = 0;
  endtask

  task automatic model_step();
    int           win;
    logic [N-1:0] rises;
    logic [N-1:0] taken;
    win   = lowest_set(m_pend & m_mask);
    rises = irq_src & ~m_prev;
    taken = '0;
    if (m_phase == 0) begin
      if (win >= 0) begin m_phase = 1; m_int = 1'b1; m_id = win; end
    end else if (m_phase == 1) begin
      if (win < 0) begin
        m_phase = 0; m_int = 1'b0;
      end else if (interrupt_grant) begin
        m_phase = 2; m_int = 1'b0; taken[m_id] = 1'b1;
      end else begin
        m_id = win;
      end
    end else begin
      if (irq_ack) m_phase = 0;
    end
    m_pend = (m_pend & ~taken) | rises;
    if (mask_we) m_mask = mask_wdata;
    m_prev = irq_src;
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".interrupt"}, 32'(interrupt), 32'(m_int));
    check({tag, ".irq_id"}, 32'(irq_id), 32'(m_id));
    check({tag, ".pending"}, 32'(irq_pending), 32'(m_pend));
    check({tag, ".mask"}, 32'(irq_mask), 32'(m_mask));
    check({tag, ".busy"}, 32'(busy), 32'(m_phase == 2));
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table: inputs applied for one edge, outputs expected after.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [N-1:0] src;
    logic         mwe;
    logic [N-1:0] mwd;
    logic         gnt;
    logic         ack;
    logic         e_int;
    logic [2:0]   e_id;
    logic [N-1:0] e_pend;
    logic [N-1:0] e_mask;
    logic         e_busy;
  } vec_t;

  vec_t vecs[24];

  initial begin
    //          src    mwe  mwd    gnt   ack   int   id    pend   mask   busy
    vecs[0]  = '{8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'hFF, 1'b0};
    vecs[1]  = '{8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h08, 8'hFF, 1'b0};
    vecs[2]  = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 8'h08, 8'hFF, 1'b0};
    vecs[3]  = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd3, 8'h00, 8'hFF, 1'b1};
    vecs[4]  = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd3, 8'h00, 8'hFF, 1'b0};
    vecs[5]  = '{8'h24, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd3, 8'h24, 8'hFF, 1'b0};
    vecs[6]  = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd2, 8'h24, 8'hFF, 1'b0};
    vecs[7]  = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd2, 8'h20, 8'hFF, 1'b1};
    vecs[8]  = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd2, 8'h20, 8'hFF, 1'b0};
    vecs[9]  = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd5, 8'h20, 8'hFF, 1'b0};
    vecs[10] = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd5, 8'h00, 8'hFF, 1'b1};
    vecs[11] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd5, 8'h00, 8'hFF, 1'b0};
    vecs[12] = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd5, 8'h00, 8'hFF, 1'b0};
    vecs[13] = '{8'h10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd5, 8'h10, 8'hFF, 1'b0};
    vecs[14] = '{8'h10, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 3'd4, 8'h10, 8'hFF, 1'b0};
    vecs[15] = '{8'h10, 1'b1, 8'hEF, 1'b0, 1'b1, 1'b1, 3'd4, 8'h10, 8'hEF, 1'b0};
    vecs[16] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd4, 8'h10, 8'hEF, 1'b0};
    vecs[17] = '{8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd4, 8'h10, 8'hFF, 1'b0};
    vecs[18] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd4, 8'h10, 8'hFF, 1'b0};
    vecs[19] = '{8'h10, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd4, 8'h10, 8'hFF, 1'b1};
    vecs[20] = '{8'h11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd4, 8'h11, 8'hFF, 1'b1};
    vecs[21] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd4, 8'h11, 8'hFF, 1'b0};
    vecs[22] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 8'h11, 8'hFF, 1'b0};
    vecs[23] = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h10, 8'hFF, 1'b1};
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b0; irq_src = '0; mask_we = 1'b0; mask_wdata = '0;
    interrupt_grant = 1'b0; irq_ack = 1'b0;
    model_reset();
    cycle(); cycle();

    check("rst.interrupt", 32'(interrupt), 32'h0);
    check("rst.irq_id", 32'(irq_id), 32'h0);
    check("rst.pending", 32'(irq_pending), 32'h0);
    check("rst.mask", 32'(irq_mask), 32'h0);
    check("rst.busy", 32'(busy), 32'h0);

    reset = 1'b1;
    #1;

    // Directed table.
    for (int i = 0; i < 24; i++) begin
      irq_src = vecs[i].src; mask_we = vecs[i].mwe; mask_wdata = vecs[i].mwd;
      interrupt_grant = vecs[i].gnt; irq_ack = vecs[i].ack;
      model_step();
      cycle();
      check($sformatf("vec%0d.interrupt", i), 32'(interrupt), 32'(vecs[i].e_int));
      check($sformatf("vec%0d.irq_id", i), 32'(irq_id), 32'(vecs[i].e_id));
      check($sformatf("vec%0d.pending", i), 32'(irq_pending), 32'(vecs[i].e_pend));
      check($sformatf("vec%0d.mask", i), 32'(irq_mask), 32'(vecs[i].e_mask));
      check($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].e_busy));
    end

    // Reset asserted while in service aborts at once; src[1] held across release.
    irq_src = 8'h02; mask_we = 1'b0; mask_wdata = '0;
    interrupt_grant = 1'b0; irq_ack = 1'b0;
    check("pre_abort.busy", 32'(busy), 32'h1);
    reset = 1'b0;
    #1;
    check("abort.interrupt", 32'(interrupt), 32'h0);
    check("abort.irq_id", 32'(irq_id), 32'h0);
    check("abort.pending", 32'(irq_pending), 32'h0);
    check("abort.mask", 32'(irq_mask), 32'h0);
    check("abort.busy", 32'(busy), 32'h0);
    model_reset();
    cycle();
    reset = 1'b1;
    #1;
    model_step();
    cycle();
    check("release.pending", 32'(irq_pending), 32'h02);
    compare_model("release");
    model_step();
    cycle();
    check("release2.pending", 32'(irq_pending), 32'h02);
    compare_model("release2");

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      irq_src         = irq_src ^ N'($urandom & $urandom);
      mask_we         = ($urandom_range(0, 7) == 0);
      mask_wdata      = N'($urandom | $urandom);
      interrupt_grant = ($urandom_range(0, 2) == 0);
      irq_ack         = ($urandom_range(0, 3) == 0);
      model_step();
      cycle();
      compare_model($sformatf("rnd%0d", c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_cpu_irq_ctrl

// File: doc/cpu_irq_ctrl.md
CPU_IRQ_CTRL -- requirements
Module: cpu_irq_ctrl

Interface
REQ-001 Parameter NUM_SRC, default 8, SHALL set the number of interrupt source lines.
REQ-002 Parameter ID_W, default 3, SHALL set the width of the source identifier, equal to clog2(NUM_SRC).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset; low clears all state immediately.
REQ-005 irq_src  input  NUM_SRC  SHALL carry the peripheral interrupt lines; a rising edge raises a request.
REQ-006 mask_we  input  1  SHALL write mask_wdata into the enable mask when high.
REQ-007 mask_wdata  input  NUM_SRC  SHALL carry the new enable mask; 1 enables the source.
REQ-008 interrupt_grant  input  1  SHALL be the one-cycle grant pulse from cpu_pc accepting the current request.
REQ-009 irq_ack  input  1  SHALL be the one-cycle end-of-service pulse from the CPU.
REQ-010 interrupt  output  1  SHALL be the registered request line to cpu_pc.
REQ-011 irq_id  output  ID_W  SHALL carry the source number being requested or serviced.
REQ-012 irq_pending  output  NUM_SRC  SHALL expose the pending-request register.
REQ-013 irq_mask  output  NUM_SRC  SHALL expose the enable mask.
REQ-014 busy  output  1  SHALL be high while in state SERVICE.

Function
REQ-015 Edge detection SHALL register irq_src into prev_src each cycle; pending[i] sets when irq_src[i]=1 and prev_src[i]=0.
REQ-016 A set and a clear of the same pending bit in the same cycle SHALL leave the bit set.
REQ-017 Pending bits SHALL be set regardless of mask; the mask SHALL gate only request generation.
REQ-018 Priority SHALL be fixed: lowest index among (pending & mask) wins.
REQ-019 The FSM SHALL have three states: IDLE, REQ, SERVICE.
REQ-020 IDLE -> REQ when (pending & mask) != 0; interrupt SHALL go high in the first cycle of REQ, one cycle after the qualifying pending bit is visible.
REQ-021 In REQ, irq_id SHALL follow the current highest-priority enabled pending source each cycle.
REQ-022 In REQ, if (pending & mask) becomes 0, for example through a mask write, the FSM SHALL return to IDLE and interrupt SHALL drop in the next cycle.
REQ-023 REQ -> SERVICE on interrupt_grant; the same edge SHALL latch irq_id, clear that pending bit (subject to REQ-016) and deassert interrupt.
REQ-024 In SERVICE, irq_id SHALL hold the latched value, and further requests SHALL remain pending with interrupt low (no nesting).
REQ-025 SERVICE -> IDLE on irq_ack; if requests are still pending, REQ SHALL be re-entered on the following cycle.
REQ-026 interrupt_grant outside REQ and irq_ack outside SERVICE SHALL be ignored.
REQ-027 A mask write SHALL take effect on the next cycle's request evaluation.

Reset
REQ-028 While reset is low, the following SHALL hold: state=IDLE, interrupt=0, irq_id=0, busy=0, pending=0, mask=0, prev_src=0.
REQ-029 Because prev_src resets to 0, a source held high across reset release SHALL pend exactly once in the first cycle after release.
REQ-030 Reset asserted mid-REQ or mid-SERVICE SHALL abort immediately; no grant or acknowledge is owed afterwards.

Structure
REQ-031 Package cpu_irq_pkg SHALL hold the state encoding (IDLE, REQ, SERVICE) and the NUM_SRC/ID_W defaults.
REQ-032 A sub-module cpu_irq_prio SHALL implement the combinational lowest-index priority encoder, outputting id and a valid flag.
REQ-033 The RTL SHALL be sized for roughly 120-250 lines in total.

Verification
REQ-034 Reset with mask=0xFF; pulse irq_src[3] -> interrupt=1 two cycles later, irq_id=3; grant -> interrupt=0, busy=1, pending=0x00.
REQ-035 Raise irq_src[5] and irq_src[2] in the same cycle -> irq_id=2; after grant and ack -> REQ re-entered, irq_id=5.
REQ-036 In REQ for source 4, write mask=0xEF -> interrupt=0 on the next cycle, state IDLE, pending[4]=1 retained.
REQ-037 During SERVICE, edge on irq_src[0] -> interrupt stays 0 and pending[0]=1; on ack, interrupt=1 with irq_id=0.
REQ-038 Drive reset low while in SERVICE -> all outputs 0 immediately; hold irq_src[1] high across release -> pending[1]=1 after one cycle.
REQ-039 Send a grant pulse in IDLE and an ack pulse in REQ -> no state change; same-cycle grant and re-edge of the granted source -> pending bit remains 1.
